// File: rtl/ring_meas_pkg.sv
// Shared types and constants for the ring-oscillator measurement path.
//   ring_state_e : averager FSM states (ACCUM collects a batch, DONE holds a result)
//   RING_CNT_W   : width of the counting circuit's gate-window count
//   acc_width()  : accumulator width that can hold a full batch sum without overflow
package ring_meas_pkg;

  localparam int unsigned RING_CNT_W = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } ring_state_e;

  function automatic int unsigned acc_width(input int unsigned w, input int unsigned l);
    return w + l;
  endfunction

endpackage

// File: rtl/ring_minmax.sv
// Running unsigned minimum/maximum of the samples in one batch.
//   clk, rst : clock and synchronous active-high clear of both trackers
//   init     : current sample is the first of the batch (loads min and max)
//   en       : a sample is accepted this cycle
//   sample   : sample value
//   min, max : tracker values including this cycle's sample when en=1
//              (combinational view so the final batch sample is included
//              without an extra cycle of latency)
module ring_minmax
  import ring_meas_pkg::*;
#(
  parameter int unsigned WIDTH = RING_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             en,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] max
);

  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;

  // Merge the incoming sample into the stored extremes.
  always_comb begin
    min = min_q;
    max = max_q;
    if (en) begin
      if (init) begin
        min = sample;
        max = sample;
      end else begin
        if (sample < min_q) min = sample;
        if (sample > max_q) max = sample;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else if (en) begin
      min_q <= min;
      max_q <= max;
    end
  end

endmodule

// File: rtl/ring_count_averager.sv
// Batch averager for ring-oscillator count samples. Accumulates
// 2^LOG2_SAMPLES samples, then presents the truncated mean (and, when the
// RING_MINMAX_EN macro is defined, the batch min/max) over valid/ready.
// Samples arriving while a result is pending are dropped and flagged.
//   clk, rst     : clock, synchronous active-high reset
//   clear        : synchronous batch abort (keeps output data and overrun)
//   sample_in    : count sample, qualified by single-cycle sample_valid
//   avg_out      : truncated batch mean
//   min_out      : batch minimum (0 without RING_MINMAX_EN)
//   max_out      : batch maximum (0 without RING_MINMAX_EN)
//   out_valid    : result pending, held until out_ready
//   overrun      : sticky, at least one sample was dropped
module ring_count_averager
  import ring_meas_pkg::*;
#(
  parameter int unsigned WIDTH        = RING_CNT_W,
  parameter int unsigned LOG2_SAMPLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] avg_out,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  localparam int unsigned ACC_W = acc_width(WIDTH, LOG2_SAMPLES);
  localparam int unsigned CNT_W = LOG2_SAMPLES;

  ring_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] avg_q, avg_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  logic [ACC_W-1:0] sum_c;
  logic             accept_c;
  logic             handshake_c;
  logic             last_c;

  // Qualified events; clear masks both acceptance and the handshake.
  assign accept_c    = !clear && (state_q == ACCUM) && sample_valid;
  assign handshake_c = !clear && (state_q == DONE) && out_valid_q && out_ready;
  assign last_c      = (cnt_q == {CNT_W{1'b1}});
  assign sum_c       = acc_q + ACC_W'(sample_in);

`ifdef RING_MINMAX_EN
  logic [WIDTH-1:0] trk_min, trk_max;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;

  ring_minmax #(
    .WIDTH(WIDTH)
  ) u_minmax (
    .clk   (clk),
    .rst   (rst || clear || handshake_c),
    .init  (cnt_q == '0),
    .en    (accept_c),
    .sample(sample_in),
    .min   (trk_min),
    .max   (trk_max)
  );

  assign min_out = min_q;
  assign max_out = max_q;
`else
  assign min_out = '0;
  assign max_out = '0;
`endif

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
`ifdef RING_MINMAX_EN
    min_d       = min_q;
    max_d       = max_q;
`endif
    if (clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept_c) begin
            if (last_c) begin
              avg_d       = WIDTH'(sum_c >> LOG2_SAMPLES);
`ifdef RING_MINMAX_EN
              min_d       = trk_min;
              max_d       = trk_max;
`endif
              out_valid_d = 1'b1;
              state_d     = DONE;
            end else begin
              acc_d = sum_c;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          // Any sample here is dropped, including in the handshake cycle.
          if (sample_valid) overrun_d = 1'b1;
          if (handshake_c) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef RING_MINMAX_EN
      min_q       <= '0;
      max_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
`ifdef RING_MINMAX_EN
      min_q       <= min_d;
      max_q       <= max_d;
`endif
    end
  end

  assign avg_out   = avg_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ring_count_averager.sv
// Self-checking bench for ring_count_averager: directed scenarios with literal
// expectations, then randomized traffic, all checked each cycle against a
// batch-level model (list of samples, pending flag, plain sum/min/max).
module tb_ring_count_averager;

  localparam int N = 8;
`ifdef RING_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clear, sample_valid, out_ready;
  logic [15:0] sample_in;
  logic [15:0] avg_out, min_out, max_out;
  logic        out_valid, overrun;

  int total = 0;
  int bad   = 0;

  // Model state.
  int          batch[$];
  bit          m_pend;
  logic [15:0] m_avg, m_min, m_max;
  bit          m_ovr;

  always #5 clk = ~clk;

  ring_count_averager #(.WIDTH(16), .LOG2_SAMPLES(3)) dut (
    .clk(clk), .rst(rst), .clear(clear), .sample_in(sample_in),
    .sample_valid(sample_valid), .avg_out(avg_out), .min_out(min_out),
    .max_out(max_out), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    int sum, mn, mx;
    if (rst) begin
      batch.delete(); m_pend = 0; m_avg = 0; m_min = 0; m_max = 0; m_ovr = 0;
    end else if (clear) begin
      batch.delete(); m_pend = 0;
    end else if (m_pend) begin
      if (sample_valid) m_ovr = 1;
      if (out_ready) begin m_pend = 0; batch.delete(); end
    end else if (sample_valid) begin
      batch.push_back(int'(sample_in));
      if (batch.size() == N) begin
        sum = 0; mn = 32'h7fffffff; mx = -1;
        foreach (batch[i]) begin
          sum += batch[i];
          if (batch[i] < mn) mn = batch[i];
          if (batch[i] > mx) mx = batch[i];
        end
        m_avg = 16'(sum / N); m_min = 16'(mn); m_max = 16'(mx);
        m_pend = 1;
        batch.delete();
      end
    end
  endtask

  // Apply inputs for one cycle, step the model at the edge, compare after it.
  task automatic cyc(input bit r, input bit c, input bit sv, input logic [15:0] s, input bit rdy);
    rst = r; clear = c; sample_valid = sv; sample_in = s; out_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_pend));
    chk("avg_out",   32'(avg_out),   32'(m_avg));
    chk("min_out",   32'(min_out),   MM ? 32'(m_min) : 32'd0);
    chk("max_out",   32'(max_out),   MM ? 32'(m_max) : 32'd0);
    chk("overrun",   32'(overrun),   32'(m_ovr));
  endtask

  initial begin
    rst = 1; clear = 0; sample_valid = 0; sample_in = 0; out_ready = 0;
    batch.delete(); m_pend = 0; m_avg = 0; m_min = 0; m_max = 0; m_ovr = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("reset_avg", 32'(avg_out), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);

    // Scenario 1: 100..107 with out_ready low.
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 16'(100 + i), 0);
      if (i == 6) chk("s1_valid_before_last", 32'(out_valid), 32'd0);
    end
    chk("s1_valid", 32'(out_valid), 32'd1);
    chk("s1_avg", 32'(avg_out), 32'd103);
    chk("s1_min", 32'(min_out), MM ? 32'd100 : 32'd0);
    chk("s1_max", 32'(max_out), MM ? 32'd107 : 32'd0);

    // Scenario 2: hold 5 cycles with two dropped strobes, then accept.
    for (int i = 0; i < 5; i++) cyc(0, 0, (i == 1 || i == 3), 16'd9999, 0);
    chk("s2_avg_stable", 32'(avg_out), 32'd103);
    chk("s2_overrun", 32'(overrun), 32'd1);
    cyc(0, 0, 0, 0, 1);
    chk("s2_valid_fall", 32'(out_valid), 32'd0);
    chk("s2_overrun_kept", 32'(overrun), 32'd1);

    // Scenario 3: full-scale samples.
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 16'hFFFF, 0);
    chk("s3_avg", 32'(avg_out), 32'hFFFF);
    chk("s3_min", 32'(min_out), MM ? 32'hFFFF : 32'd0);
    chk("s3_max", 32'(max_out), MM ? 32'hFFFF : 32'd0);
    cyc(0, 0, 0, 0, 1);

    // Scenario 4: abort a partial batch with clear (sample in clear cycle).
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 16'd50, 0);
    cyc(0, 1, 1, 16'd50, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 16'd10, 0);
      if (i == 3) chk("s4_no_early_result", 32'(out_valid), 32'd0);
    end
    chk("s4_avg", 32'(avg_out), 32'd10);
    chk("s4_min", 32'(min_out), MM ? 32'd10 : 32'd0);
    chk("s4_max", 32'(max_out), MM ? 32'd10 : 32'd0);
    chk("s4_overrun", 32'(overrun), 32'd0);
    cyc(0, 0, 0, 0, 1);

    // Scenario 5: reset mid-batch.
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 16'd200, 0);
    cyc(1, 0, 0, 0, 0);
    chk("s5_reset_avg", 32'(avg_out), 32'd0);
    chk("s5_reset_min", 32'(min_out), 32'd0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 16'd7, 0);
    chk("s5_avg", 32'(avg_out), 32'd7);
    cyc(0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, c, sv, rdy;
      logic [15:0] s;
      r   = ($urandom_range(0, 499) == 0);
      c   = ($urandom_range(0, 79) == 0);
      sv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      s   = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      cyc(r, c, sv, s, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
